// File: rtl/rv32_mem_arb_pkg.sv
// Shared types for the rv32imc_ss memory-port arbiter.
// Grant states, owner tag and the latched bus transaction.
package rv32_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_I = 1'b1
  } owner_e;

  localparam logic [3:0] FETCH_BE = 4'b1111;

  typedef struct packed {
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_txn_t;

endpackage

// File: rtl/rv32_mod_mem_arb_pick.sv
// Fetch/LSU winner selection with a saturating fetch-starvation counter.
// Data wins ties until STARVE_LIMIT data grants were made while fetch waited.
module rv32_mod_mem_arb_pick #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  input  logic gnt,
  output logic fetch_win
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q;
  logic [3:0] starve_cnt_d;

  always_comb begin
    fetch_win = 1'b0;
    if (i_req && d_req) begin
      fetch_win = (starve_cnt_q == LIMIT);
    end else if (i_req) begin
      fetch_win = 1'b1;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!i_req) begin
      starve_cnt_d = '0;
    end else if (gnt && fetch_win) begin
      starve_cnt_d = '0;
    end else if (gnt && starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/rv32_mod_mem_arbiter.sv
// Fetch/LSU arbiter for the single rv32imc_ss memory port.
// Optional bus-ack watchdog: define RV32_MEM_ARB_TIMEOUT_EN.
module rv32_mod_mem_arbiter
  import rv32_mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_data_o,
  output logic        i_ack,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_data_i,
  output logic [31:0] d_data_o,
  output logic        d_ack,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack,
  input  logic        mem_err
);

  arb_state_e state_q, state_d;
  mem_txn_t   txn_q, txn_d;
  owner_e     win;
  logic       fetch_win;
  logic       busy, done, gnt, tmo;
  logic       own_d, own_i, bus_ok, bus_bad;

  assign busy  = (state_q != IDLE);
  assign own_d = (state_q == GNT_D);
  assign own_i = (state_q == GNT_I);
  assign done  = busy && (mem_ack || mem_err || tmo);
  assign win   = fetch_win ? OWN_I : OWN_D;

  rv32_mod_mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .d_req    (d_req),
    .gnt      (gnt),
    .fetch_win(fetch_win)
  );

`ifdef RV32_MEM_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt_q, wait_cnt_d;

  assign tmo = busy && !mem_ack && !mem_err &&
               (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (gnt) begin
      wait_cnt_d = '0;
    end else if (busy && !mem_ack && !mem_err) begin
      wait_cnt_d = wait_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  // Watchdog compiled out; a zero limit is outside the legal range.
  assign tmo = (TIMEOUT_CYCLES == 0);
`endif

  // Completion re-arbitrates both requesters, so back-to-back grants
  // keep mem_req high and honour the starvation bound.
  always_comb begin
    state_d = state_q;
    txn_d   = txn_q;
    gnt     = 1'b0;
    if (!busy || done) begin
      state_d = IDLE;
      if (i_req || d_req) begin
        gnt = 1'b1;
        if (win == OWN_I) begin
          state_d     = GNT_I;
          txn_d.wr    = 1'b0;
          txn_d.be    = FETCH_BE;
          txn_d.addr  = i_addr;
          txn_d.wdata = '0;
        end else begin
          state_d     = GNT_D;
          txn_d.wr    = d_wr;
          txn_d.be    = d_be;
          txn_d.addr  = d_addr;
          txn_d.wdata = d_data_i;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
    end
  end

  assign bus_ok  = mem_ack && !mem_err;
  assign bus_bad = mem_err || tmo;

  assign mem_req    = busy && !tmo;
  assign mem_wr     = txn_q.wr;
  assign mem_be     = txn_q.be;
  assign mem_addr   = txn_q.addr;
  assign mem_data_o = txn_q.wdata;

  assign i_ack    = own_i && bus_ok;
  assign i_err    = own_i && bus_bad;
  assign d_ack    = own_d && bus_ok;
  assign d_err    = own_d && bus_bad;
  assign i_data_o = busy ? mem_data_i : '0;
  assign d_data_o = busy ? mem_data_i : '0;

endmodule
